// File: rtl/bin_tape_loader.sv
// PDP-8 BIN paper-tape loader: decodes field/origin/data frames, writes words to core
// memory with one-word lookahead so the trailing checksum word is never stored.
module bin_tape_loader #(
  parameter int LEADER_MIN = 8,
  parameter int MEM_AWIDTH = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_wren,
  output logic [MEM_AWIDTH-1:0] mem_waddr,
  output logic [11:0]           mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  cksum_ok,
  output logic                  cksum_err,
  output logic [15:0]           words_written
);

  localparam int FW = MEM_AWIDTH - 12;
  localparam int LW = $clog2(LEADER_MIN + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEADER  = 3'd1,
    S_FRAME   = 3'd2,
    S_ORG_LO  = 3'd3,
    S_DATA_LO = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  function automatic logic [11:0] sum_add(input logic [11:0] s, input logic [7:0] b);
    return s + {4'd0, b};
  endfunction

  state_t          state_r, state_s;
  logic [LW-1:0]   lcnt_r, lcnt_s;
  logic            skip_r, skip_s;
  logic [11:0]     sum_r, sum_s;
  logic [FW-1:0]   field_r, field_s;
  logic [11:0]     addr_r, addr_s;
  logic [5:0]      hi_r, hi_s;
  logic            pend_r, pend_s;
  logic [11:0]     pword_r, pword_s;
  logic [5:0]      phi_r, phi_s;
  logic [5:0]      plo_r, plo_s;
  logic            seen_r, seen_s;
  logic [15:0]     count_r, count_s;
  logic            ok_r, ok_s;
  logic            err_r, err_s;
  logic            wren_r, wren_s;
  logic [MEM_AWIDTH-1:0] waddr_r, waddr_s;
  logic [11:0]     wdata_r, wdata_s;
  logic            busy_r, done_r, ready_r;
  logic            accept_s, commit_s, add_org_s, set_field_s, act_s;

  assign accept_s = in_valid & ready_r;
  // Bytes between a pair of rubouts, and rubouts themselves, take no further part in decoding.
  assign act_s    = accept_s & (in_data != 8'hFF) & ~skip_r;

  // Next-state and datapath decode for one accepted tape byte.
  always_comb begin
    state_s     = state_r;
    lcnt_s      = lcnt_r;
    skip_s      = skip_r;
    sum_s       = sum_r;
    field_s     = field_r;
    addr_s      = addr_r;
    hi_s        = hi_r;
    pend_s      = pend_r;
    pword_s     = pword_r;
    phi_s       = phi_r;
    plo_s       = plo_r;
    seen_s      = seen_r;
    count_s     = count_r;
    ok_s        = ok_r;
    err_s       = err_r;
    wren_s      = 1'b0;
    waddr_s     = waddr_r;
    wdata_s     = wdata_r;
    commit_s    = 1'b0;
    add_org_s   = 1'b0;
    set_field_s = 1'b0;

    case (state_r)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_s = S_LEADER;
          lcnt_s  = '0;
          skip_s  = 1'b0;
          sum_s   = 12'd0;
          field_s = '0;
          addr_s  = 12'd0;
          pend_s  = 1'b0;
          seen_s  = 1'b0;
          count_s = 16'd0;
          ok_s    = 1'b0;
          err_s   = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      S_LEADER: begin
        if (accept_s && in_data == 8'hFF) begin
          skip_s = ~skip_r;
        end else if (!act_s) begin
          skip_s = skip_r;
        end else if (in_data == 8'h80) begin
          lcnt_s = lcnt_r + 1'b1;
          if (lcnt_s >= LW'(LEADER_MIN)) begin
            state_s = S_FRAME;
          end else begin
            state_s = S_LEADER;
          end
        end else begin
          lcnt_s = '0;
        end
      end
      S_FRAME: begin
        if (accept_s && in_data == 8'hFF) begin
          skip_s = ~skip_r;
        end else if (!act_s) begin
          skip_s = skip_r;
        end else begin
          case (in_data[7:6])
            2'b00: begin
              commit_s = pend_r;
              hi_s     = in_data[5:0];
              seen_s   = 1'b1;
              state_s  = S_DATA_LO;
            end
            2'b01: begin
              commit_s  = pend_r;
              add_org_s = 1'b1;
              hi_s      = in_data[5:0];
              seen_s    = 1'b1;
              state_s   = S_ORG_LO;
            end
            2'b11: begin
              commit_s    = pend_r;
              set_field_s = 1'b1;
              seen_s      = 1'b1;
            end
            default: begin
              if (in_data != 8'h80) begin
                err_s   = 1'b1;
                state_s = S_DONE;
              end else if (seen_r) begin
                // Trailer: the held-back word is the checksum, compared but never written.
                ok_s    = pend_r & (sum_r == pword_r);
                err_s   = ~(pend_r & (sum_r == pword_r));
                state_s = S_DONE;
              end else begin
                state_s = S_FRAME;
              end
            end
          endcase
        end
      end
      S_ORG_LO: begin
        if (!accept_s) begin
          state_s = state_r;
        end else if (in_data[7:6] != 2'b00) begin
          err_s   = 1'b1;
          state_s = S_DONE;
        end else begin
          addr_s  = {hi_r, in_data[5:0]};
          sum_s   = sum_add(sum_r, in_data);
          state_s = S_FRAME;
        end
      end
      S_DATA_LO: begin
        if (!accept_s) begin
          state_s = state_r;
        end else if (in_data[7:6] != 2'b00) begin
          err_s   = 1'b1;
          state_s = S_DONE;
        end else begin
          pend_s  = 1'b1;
          pword_s = {hi_r, in_data[5:0]};
          phi_s   = hi_r;
          plo_s   = in_data[5:0];
          state_s = S_FRAME;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase

    // Commit precedes the origin-byte sum and the field change carried by the same byte.
    if (commit_s) begin
      wren_s  = 1'b1;
      waddr_s = {field_r, addr_r};
      wdata_s = pword_r;
      sum_s   = sum_add(sum_add(sum_r, {2'b00, phi_r}), {2'b00, plo_r});
      addr_s  = addr_r + 12'd1;
      count_s = count_r + 16'd1;
      pend_s  = 1'b0;
    end else begin
      wren_s  = 1'b0;
    end
    if (add_org_s) begin
      sum_s = sum_add(sum_s, in_data);
    end else begin
      sum_s = sum_s;
    end
    if (set_field_s) begin
      field_s = FW'(in_data[5:3]);
    end else begin
      field_s = field_s;
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      lcnt_r  <= '0;
      skip_r  <= 1'b0;
      sum_r   <= 12'd0;
      field_r <= '0;
      addr_r  <= 12'd0;
      hi_r    <= 6'd0;
      pend_r  <= 1'b0;
      pword_r <= 12'd0;
      phi_r   <= 6'd0;
      plo_r   <= 6'd0;
      seen_r  <= 1'b0;
      count_r <= 16'd0;
      ok_r    <= 1'b0;
      err_r   <= 1'b0;
      wren_r  <= 1'b0;
      waddr_r <= '0;
      wdata_r <= 12'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      ready_r <= 1'b0;
    end else begin
      state_r <= state_s;
      lcnt_r  <= lcnt_s;
      skip_r  <= skip_s;
      sum_r   <= sum_s;
      field_r <= field_s;
      addr_r  <= addr_s;
      hi_r    <= hi_s;
      pend_r  <= pend_s;
      pword_r <= pword_s;
      phi_r   <= phi_s;
      plo_r   <= plo_s;
      seen_r  <= seen_s;
      count_r <= count_s;
      ok_r    <= ok_s;
      err_r   <= err_s;
      wren_r  <= wren_s;
      waddr_r <= waddr_s;
      wdata_r <= wdata_s;
      busy_r  <= (state_s == S_LEADER) || (state_s == S_FRAME) ||
                 (state_s == S_ORG_LO) || (state_s == S_DATA_LO);
      ready_r <= (state_s == S_LEADER) || (state_s == S_FRAME) ||
                 (state_s == S_ORG_LO) || (state_s == S_DATA_LO);
      done_r  <= (state_s == S_DONE);
    end
  end

  assign in_ready      = ready_r;
  assign mem_wren      = wren_r;
  assign mem_waddr     = waddr_r;
  assign mem_wdata     = wdata_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign cksum_ok      = ok_r;
  assign cksum_err     = err_r;
  assign words_written = count_r;

endmodule

// File: tb/tb_bin_tape_loader.sv
// Scoreboard bench for bin_tape_loader: directed tapes push expected writes and end status;
// a negedge monitor pops and compares whenever the DUT strobes a write or raises done.
module tb_bin_tape_loader;

  logic        clk = 1'b0;
  logic        rst_n, start, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, mem_wren, busy, done, cksum_ok, cksum_err;
  logic [14:0] mem_waddr;
  logic [11:0] mem_wdata;
  logic [15:0] words_written;

  typedef struct packed { logic [14:0] addr; logic [11:0] data; } wr_t;
  typedef struct packed { logic ok; logic err; logic [15:0] cnt; } st_t;

  wr_t        wq[$];
  st_t        sq[$];
  logic [7:0] tape[$];
  int checks = 0, errors = 0;
  int req_cnt = 0, req_seen = 0, tmo_cnt = 0, tmo_seen = 0;

  bin_tape_loader #(.LEADER_MIN(8), .MEM_AWIDTH(15)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_wren(mem_wren), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .cksum_ok(cksum_ok), .cksum_err(cksum_err),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  // Monitor: the only process that compares and counts.
  initial begin
    logic done_q;
    wr_t  w;
    st_t  s;
    done_q = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_wren) begin
        checks++;
        if (wq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write got addr=%h data=%h want no write", mem_waddr, mem_wdata);
        end else begin
          w = wq.pop_front();
          if (mem_waddr !== w.addr || mem_wdata !== w.data) begin
            errors++;
            $display("FAIL write got addr=%h data=%h want addr=%h data=%h",
                     mem_waddr, mem_wdata, w.addr, w.data);
          end
        end
      end
      if (done && !done_q) begin
        checks++;
        if (sq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done got done=1 want 0");
        end else begin
          s = sq.pop_front();
          if (cksum_ok !== s.ok) begin
            errors++;
            $display("FAIL cksum_ok got %b want %b", cksum_ok, s.ok);
          end
          checks++;
          if (cksum_err !== s.err) begin
            errors++;
            $display("FAIL cksum_err got %b want %b", cksum_err, s.err);
          end
          checks++;
          if (words_written !== s.cnt) begin
            errors++;
            $display("FAIL words_written got %0d want %0d", words_written, s.cnt);
          end
          checks++;
          if (wq.size() != 0) begin
            errors++;
            $display("FAIL missing_writes got %0d outstanding want 0", wq.size());
            wq.delete();
          end
        end
      end
      done_q = done;
      if (req_cnt != req_seen) begin
        req_seen = req_cnt;
        checks++;
        if ({mem_wren, mem_waddr, mem_wdata, busy, done, cksum_ok, cksum_err,
             words_written, in_ready} !== 49'd0) begin
          errors++;
          $display("FAIL idle_outputs got wren=%b addr=%h data=%h busy=%b done=%b ok=%b err=%b cnt=%0d rdy=%b want all 0",
                   mem_wren, mem_waddr, mem_wdata, busy, done, cksum_ok, cksum_err,
                   words_written, in_ready);
        end
      end
      if (tmo_cnt != tmo_seen) begin
        tmo_seen = tmo_cnt;
        checks++;
        errors++;
        $display("FAIL timeout got no response want progress");
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int n;
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) tmo_cnt++;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_tape();
    int n;
    pulse_start();
    for (int i = 0; i < 8; i++) send(8'h80);
    foreach (tape[i]) send(tape[i]);
    n = 0;
    while (!done && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) tmo_cnt++;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1 req_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    req_cnt++;
    @(posedge clk); #1;

    // Reference tape: origin 0200, two words, checksum 0x0A3.
    tape = '{8'h42, 8'h00, 8'h3B, 8'h00, 8'h0A, 8'h1C, 8'h02, 8'h23, 8'h80};
    wq.push_back('{15'h0080, 12'hEC0}); wq.push_back('{15'h0081, 12'h29C});
    sq.push_back('{1'b1, 1'b0, 16'd2});
    run_tape();

    // Bad checksum word 0x0A4.
    tape = '{8'h42, 8'h00, 8'h3B, 8'h00, 8'h0A, 8'h1C, 8'h02, 8'h24, 8'h80};
    wq.push_back('{15'h0080, 12'hEC0}); wq.push_back('{15'h0081, 12'h29C});
    sq.push_back('{1'b0, 1'b1, 16'd2});
    run_tape();

    // Field 2 selected before origin; field byte is not summed.
    tape = '{8'hD0, 8'h42, 8'h00, 8'h3B, 8'h00, 8'h0A, 8'h1C, 8'h02, 8'h23, 8'h80};
    wq.push_back('{15'h2080, 12'hEC0}); wq.push_back('{15'h2081, 12'h29C});
    sq.push_back('{1'b1, 1'b0, 16'd2});
    run_tape();

    // Origin 7777 then two words: address wraps to 0000; sum 0xBE+3+7 = 0xC8.
    tape = '{8'h7F, 8'h3F, 8'h01, 8'h02, 8'h03, 8'h04, 8'h03, 8'h08, 8'h80};
    wq.push_back('{15'h0FFF, 12'h042}); wq.push_back('{15'h0000, 12'h0C4});
    sq.push_back('{1'b1, 1'b0, 16'd2});
    run_tape();

    // Rubout-delimited garbage (including 0x80 and 0x85) is ignored.
    tape = '{8'h42, 8'h00, 8'h3B, 8'h00, 8'hFF, 8'h12, 8'h85, 8'h80, 8'hFF,
             8'h0A, 8'h1C, 8'h02, 8'h23, 8'h80};
    wq.push_back('{15'h0080, 12'hEC0}); wq.push_back('{15'h0081, 12'h29C});
    sq.push_back('{1'b1, 1'b0, 16'd2});
    run_tape();

    // Data-high commits the pending word, then 0x85 as second byte is a framing error.
    tape = '{8'h42, 8'h00, 8'h3B, 8'h00, 8'h00, 8'h85};
    wq.push_back('{15'h0080, 12'hEC0});
    sq.push_back('{1'b0, 1'b1, 16'd1});
    run_tape();

    // 0x85 frame with a word pending: error, pending word not written.
    tape = '{8'h42, 8'h00, 8'h3B, 8'h00, 8'h85};
    sq.push_back('{1'b0, 1'b1, 16'd0});
    run_tape();

    // Trailer with nothing pending.
    tape = '{8'h42, 8'h00, 8'h80};
    sq.push_back('{1'b0, 1'b1, 16'd0});
    run_tape();

    // Reset between the two bytes of a data word.
    pulse_start();
    for (int i = 0; i < 8; i++) send(8'h80);
    send(8'h42); send(8'h00); send(8'h3B);
    rst_n = 1'b0;
    req_cnt++;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 8'h00;
    req_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'h1C;
      req_cnt++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bin_tape_loader.md
# bin_tape_loader

Streams a PDP-8 BIN-format paper-tape image, one 8-bit frame per byte from the host/UART receiver, and writes the decoded 12-bit words into core memory through its write port. It decodes field-setting, origin and data frames and verifies the trailing checksum. It sits directly upstream of the core memory write port (wren/waddr/wdata) and drives it while the CPU is held stopped.

## Interface
- `LEADER_MIN`, default 8: consecutive 0x80 bytes required to recognise leader.
- `clk` in 1: system clock, all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; arms a load. Honoured only in IDLE or DONE.
- `in_valid` in 1: `in_data` holds a tape byte.
- `in_data` in 8: tape frame byte.
- `in_ready` out 1: byte accepted on an edge where `in_valid & in_ready`.
- `mem_wren` out 1: one-cycle write strobe to core memory.
- `mem_waddr` out `MEM_AWIDTH`: {field, 12-bit address}; field = upper `MEM_AWIDTH-12` bits.
- `mem_wdata` out 12: word to write.
- `busy` out 1: high from accepted `start` until DONE.
- `done` out 1: high in DONE until next `start`.
- `cksum_ok` out 1: valid when `done`; checksum matched.
- `cksum_err` out 1: valid when `done`; checksum mismatch, framing error, or empty tape.
- `words_written` out 16: count of committed words, wraps.

## Operation
- States: IDLE, LEADER, FRAME, ORG_LO, DATA_LO, DONE. `in_ready` = 1 in LEADER/FRAME/ORG_LO/DATA_LO, else 0.
- `start`: clear sum, field, address, pending flag, count, flags; go LEADER.
- LEADER: count consecutive 0x80; any other byte clears count. Count reaching `LEADER_MIN` -> FRAME; further 0x80 stay in FRAME as leader.
- Rubout 0xFF in FRAME/LEADER toggles skip mode; while skipping, all bytes except 0xFF are discarded.
- FRAME byte decode (bits 7:6):
  - 00: data high 6 bits -> DATA_LO.
  - 01: origin high 6 bits -> ORG_LO.
  - 11 (not 0xFF): field = bits 5:3; not summed.
  - 10: 0x80 = trailer if at least one frame seen, else leader; 0x81–0xBF = framing error.
- Second byte (ORG_LO/DATA_LO) must have bits 7:6 = 00, else framing error.
- Checksum: 12-bit modulo sum of all raw origin and data bytes (including the 0x40 marker). Field and leader bytes are excluded.
- One-word lookahead: a completed data word becomes *pending*, and its bytes are not yet summed.
  - The next data word, origin-high byte or field byte first commits the pending word: write at the current address, add its bytes to the sum, increment the 12-bit address (wraps within the field), increment the count.
  - Origin loads the address at ORG_LO completion.
  - Field change applies after the commit.
- Trailer: the pending word is the checksum and is never written. Set `cksum_ok` = (sum == pending), `cksum_err` = !that; -> DONE. With no pending word, `cksum_err` = 1.
- Framing error: no commit of the pending word; `cksum_err` = 1; -> DONE.
- DONE ignores input until `start`.

## Timing
- Reset values: state IDLE, all outputs 0, `mem_waddr` = 0, `mem_wdata` = 0, `in_ready` = 0.
- `mem_wren`, `mem_waddr`, `mem_wdata` are registered. The strobe occurs the cycle after the committing byte is accepted and lasts exactly 1 cycle. Address and data are stable during the strobe.
- Throughput is one byte per cycle; no stall is required, since memory writes take a single cycle.
- `done`/`cksum_*` rise the cycle after the trailer byte is accepted. `busy` falls in the same cycle.
- `start` while busy is ignored. `start` in the same cycle as a byte arrives in DONE is honoured and the byte is dropped.
- `rst_n` low mid-load aborts immediately; no strobe is issued after assertion.

## Test plan
- 8×0x80, 0x42,0x00, 0x3B,0x00, 0x0A,0x1C, 0x02,0x23, 0x80 -> writes (0x0080, 0xEC0) and (0x0081, 0x29C); no write of 0x0A3; `done` = 1, `cksum_ok` = 1, `words_written` = 2.
- Same tape with checksum bytes 0x02,0x24 -> same two writes; `cksum_err` = 1.
- Field byte 0xD0 before the origin in the first tape -> writes at 0x2080 and 0x2081; checksum still ok.
- Origin 0o7777 (0x7F,0x3F) followed by two data words -> second write at address 0x000 of the same field; checksum ok.
- 0x00 data-high followed by 0x85 -> `cksum_err` = 1, no write of the pending word; 0xFF … 0xFF region with garbage inside -> ignored.
- `rst_n` pulsed between the data bytes of a word -> all outputs 0, no `mem_wren`; bytes ignored until `start`.
